// File: rtl/snake_game_engine.sv
// Snake play-field engine: body shift array, steering, food pickup, self-collision
// and a registered cell-occupancy query for the renderer.
module snake_game_engine #(
    parameter int GRID_BITS = 4,
    parameter int MAX_LEN   = 16,
    parameter int INIT_LEN  = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [1:0]           STATE_IN,
    input  logic                 MOVE_TICK,
    input  logic [3:0]           DIR_BUTTONS,
    input  logic [GRID_BITS-1:0] FOOD_X,
    input  logic [GRID_BITS-1:0] FOOD_Y,
    input  logic [GRID_BITS-1:0] QUERY_X,
    input  logic [GRID_BITS-1:0] QUERY_Y,
    output logic [3:0]           SCORE_OUT,
    output logic                 SUICIDE_OUT,
    output logic                 FOOD_EATEN,
    output logic [GRID_BITS-1:0] HEAD_X,
    output logic [GRID_BITS-1:0] HEAD_Y,
    output logic [4:0]           LENGTH_OUT,
    output logic                 QUERY_HIT
);

    localparam logic [1:0]           ST_IDLE   = 2'b00;
    localparam logic [1:0]           ST_PLAY   = 2'b01;
    localparam int                   CENTER    = 1 << (GRID_BITS - 1);
    localparam logic [GRID_BITS-1:0] ONE       = 1;
    localparam logic [4:0]           MAX_LEN_L = 5'(MAX_LEN);
    localparam logic [4:0]           INIT_LEN_L = 5'(INIT_LEN);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    logic [GRID_BITS-1:0] r_seg_x [MAX_LEN];
    logic [GRID_BITS-1:0] r_seg_y [MAX_LEN];
    logic [4:0]           r_len;
    dir_t                 r_dir;
    dir_t                 r_pend;
    logic [3:0]           r_score;
    logic                 r_suicide;
    logic                 r_food_eaten;
    logic                 r_query_hit;

    logic                 w_init;
    logic                 w_move;
    logic                 w_step;
    logic                 w_grow;
    logic                 w_collide;
    dir_t                 w_req;
    dir_t                 w_pend;
    logic [GRID_BITS-1:0] w_nh_x;
    logic [GRID_BITS-1:0] w_nh_y;
    logic [4:0]           w_hit_lim;
    logic [MAX_LEN-1:0]   w_body_hit;
    logic [MAX_LEN-1:0]   w_query_match;

    assign w_init = !RESET || (STATE_IN == ST_IDLE);
    assign w_move = MOVE_TICK && (STATE_IN == ST_PLAY) && !r_suicide;

    // Steering: highest-priority pressed button, unless it would reverse the snake.
    always_comb begin
        w_req  = DIR_RIGHT;
        w_pend = r_pend;
        if (DIR_BUTTONS[0])      w_req = DIR_UP;
        else if (DIR_BUTTONS[1]) w_req = DIR_DOWN;
        else if (DIR_BUTTONS[2]) w_req = DIR_LEFT;
        if ((STATE_IN == ST_PLAY) && (|DIR_BUTTONS) && (w_req != opposite(r_dir)))
            w_pend = w_req;
    end

    always_comb begin
        w_nh_x = r_seg_x[0];
        w_nh_y = r_seg_y[0];
        case (w_pend)
            DIR_UP:   w_nh_y = r_seg_y[0] - ONE;
            DIR_DOWN: w_nh_y = r_seg_y[0] + ONE;
            DIR_LEFT: w_nh_x = r_seg_x[0] - ONE;
            default:  w_nh_x = r_seg_x[0] + ONE;
        endcase
    end

    assign w_grow    = (w_nh_x == FOOD_X) && (w_nh_y == FOOD_Y);
    // Without growth the tail cell vacates in the same step, so it is excluded.
    assign w_hit_lim = w_grow ? r_len : (r_len - 5'd1);

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
        localparam logic [4:0] IDX = 5'(gi);
        assign w_body_hit[gi]    = (IDX < w_hit_lim) &&
                                   (r_seg_x[gi] == w_nh_x) && (r_seg_y[gi] == w_nh_y);
        assign w_query_match[gi] = (IDX < r_len) &&
                                   (r_seg_x[gi] == QUERY_X) && (r_seg_y[gi] == QUERY_Y);
    end

    assign w_collide = |w_body_hit;
    assign w_step    = w_move && !w_collide;

    always_ff @(posedge CLOCK) begin
        if (w_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? GRID_BITS'(CENTER - i) : '0;
                r_seg_y[i] <= (i < INIT_LEN) ? GRID_BITS'(CENTER) : '0;
            end
            r_len        <= INIT_LEN_L;
            r_dir        <= DIR_RIGHT;
            r_pend       <= DIR_RIGHT;
            r_score      <= 4'd0;
            r_suicide    <= 1'b0;
            r_food_eaten <= 1'b0;
            r_query_hit  <= 1'b0;
        end else begin
            r_pend       <= w_pend;
            r_food_eaten <= 1'b0;
            r_query_hit  <= |w_query_match;
            if (w_move && w_collide)
                r_suicide <= 1'b1;
            if (w_step) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0] <= w_nh_x;
                r_seg_y[0] <= w_nh_y;
                r_dir      <= w_pend;
                if (w_grow) begin
                    if (r_len < MAX_LEN_L)
                        r_len <= r_len + 5'd1;
                    if (r_score != 4'hF)
                        r_score <= r_score + 4'd1;
                    r_food_eaten <= 1'b1;
                end
            end
        end
    end

    assign SCORE_OUT   = r_score;
    assign SUICIDE_OUT = r_suicide;
    assign FOOD_EATEN  = r_food_eaten;
    assign HEAD_X      = r_seg_x[0];
    assign HEAD_Y      = r_seg_y[0];
    assign LENGTH_OUT  = r_len;
    assign QUERY_HIT   = r_query_hit;

endmodule

// File: tb/tb_snake_game_engine.sv
// Bench for snake_game_engine: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_snake_game_engine;

    localparam int GB = 4;
    localparam int ML = 16;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    state;
    logic          tick;
    logic [3:0]    btn;
    logic [GB-1:0] fx, fy, qx, qy;
    logic [3:0]    score;
    logic          suicide, food_eaten, qhit;
    logic [GB-1:0] head_x, head_y;
    logic [4:0]    len;

    always #5 clk = ~clk;

    snake_game_engine #(.GRID_BITS(GB), .MAX_LEN(ML), .INIT_LEN(3)) dut (
        .CLOCK(clk), .RESET(rst_n), .STATE_IN(state), .MOVE_TICK(tick),
        .DIR_BUTTONS(btn), .FOOD_X(fx), .FOOD_Y(fy), .QUERY_X(qx), .QUERY_Y(qy),
        .SCORE_OUT(score), .SUICIDE_OUT(suicide), .FOOD_EATEN(food_eaten),
        .HEAD_X(head_x), .HEAD_Y(head_y), .LENGTH_OUT(len), .QUERY_HIT(qhit)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Directions: 0 up, 1 down, 2 left, 3 right
    function automatic int rev(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int step_x(input int x, input int d);
        if (d == 2) return (x + W - 1) % W;
        if (d == 3) return (x + 1) % W;
        return x;
    endfunction

    function automatic int step_y(input int y, input int d);
        if (d == 0) return (y + W - 1) % W;
        if (d == 1) return (y + 1) % W;
        return y;
    endfunction

    // Reference model: body as queues, index 0 is the head.
    int m_bx[$];
    int m_by[$];
    int m_dir, m_pend, m_score;
    bit m_suicide, m_fe, m_qhit, m_valid = 0;
    int mt_req, mt_nx, mt_ny, mt_lim;
    bit mt_grow, mt_col;

    always @(posedge clk) begin
        if (!rst_n || state == 2'b00) begin
            m_bx = {8, 7, 6};
            m_by = {8, 8, 8};
            m_dir = 3; m_pend = 3; m_score = 0;
            m_suicide = 0; m_fe = 0; m_qhit = 0; m_valid = 1;
        end else if (m_valid) begin
            m_qhit = 0;
            for (int i = 0; i < m_bx.size(); i++)
                if (m_bx[i] == int'(qx) && m_by[i] == int'(qy)) m_qhit = 1;
            m_fe = 0;
            if (state == 2'b01) begin
                mt_req = -1;
                if (btn[0]) mt_req = 0;
                else if (btn[1]) mt_req = 1;
                else if (btn[2]) mt_req = 2;
                else if (btn[3]) mt_req = 3;
                if (mt_req >= 0 && mt_req != rev(m_dir)) m_pend = mt_req;
                if (tick && !m_suicide) begin
                    mt_nx = step_x(m_bx[0], m_pend);
                    mt_ny = step_y(m_by[0], m_pend);
                    mt_grow = (mt_nx == int'(fx)) && (mt_ny == int'(fy));
                    mt_lim = mt_grow ? m_bx.size() : m_bx.size() - 1;
                    mt_col = 0;
                    for (int i = 0; i < mt_lim; i++)
                        if (m_bx[i] == mt_nx && m_by[i] == mt_ny) mt_col = 1;
                    if (mt_col) begin
                        m_suicide = 1;
                    end else begin
                        m_bx.push_front(mt_nx);
                        m_by.push_front(mt_ny);
                        if (!mt_grow || m_bx.size() > ML) begin
                            void'(m_bx.pop_back());
                            void'(m_by.pop_back());
                        end
                        m_dir = m_pend;
                        if (mt_grow) begin
                            if (m_score < 15) m_score++;
                            m_fe = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("head_x", 32'(head_x), m_bx[0]);
            chk("head_y", 32'(head_y), m_by[0]);
            chk("length", 32'(len), m_bx.size());
            chk("score", 32'(score), m_score);
            chk("suicide", 32'(suicide), 32'(m_suicide));
            chk("food_eaten", 32'(food_eaten), 32'(m_fe));
            chk("query_hit", 32'(qhit), 32'(m_qhit));
        end
    end

    task automatic cyc(input bit t, input logic [3:0] b);
        tick = t;
        btn  = b;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        btn  = 4'd0;
        if (t)
            $display("tick: head=(%0d,%0d) len=%0d score=%0d suicide=%0d eaten=%0d",
                     head_x, head_y, len, score, suicide, food_eaten);
    endtask

    int r, pick;
    bit t;
    logic [3:0] b;

    initial begin
        rst_n = 1'b0; state = 2'b01; tick = 1'b0; btn = 4'd0;
        fx = 4'd0; fy = 4'd15; qx = 4'd0; qy = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_reset_head_x", 32'(head_x), 8);
        chk("lit_reset_head_y", 32'(head_y), 8);
        chk("lit_reset_len", 32'(len), 3);
        chk("lit_reset_score", 32'(score), 0);
        chk("lit_reset_qhit", 32'(qhit), 0);
        rst_n = 1'b1;

        qx = 4'd7; qy = 4'd8; cyc(0, 4'b0000);
        chk("lit_query_7_8", 32'(qhit), 1);
        qx = 4'd0; qy = 4'd0; cyc(0, 4'b0000);
        chk("lit_query_0_0", 32'(qhit), 0);
        cyc(1, 4'b0000);
        chk("lit_tick1_head_x", 32'(head_x), 9);
        qx = 4'd6; qy = 4'd8; cyc(0, 4'b0000);
        chk("lit_query_6_8", 32'(qhit), 0);
        qx = 4'd0; qy = 4'd0; cyc(1, 4'b0000);
        chk("lit_tick2_head_x", 32'(head_x), 10);

        fx = 4'd11; fy = 4'd8; cyc(1, 4'b0000);
        chk("lit_eat_len", 32'(len), 4);
        chk("lit_eat_score", 32'(score), 1);
        chk("lit_eat_pulse", 32'(food_eaten), 1);
        fx = 4'd0; fy = 4'd15; qx = 4'd8; qy = 4'd8; cyc(0, 4'b0000);
        chk("lit_eat_pulse_end", 32'(food_eaten), 0);
        chk("lit_tail_kept", 32'(qhit), 1);

        cyc(0, 4'b0100); cyc(1, 4'b0000);
        chk("lit_reverse_ignored", 32'(head_x), 12);
        cyc(0, 4'b1001); cyc(1, 4'b0000);
        chk("lit_up_wins", 32'(head_y), 7);
        repeat (7) cyc(1, 4'b0000);
        chk("lit_at_top", 32'(head_y), 0);
        cyc(1, 4'b0000);
        chk("lit_wrap_y", 32'(head_y), 15);

        cyc(0, 4'b1000); cyc(1, 4'b0000);
        cyc(0, 4'b0010); cyc(1, 4'b0000);
        cyc(0, 4'b0100); cyc(1, 4'b0000);
        cyc(0, 4'b0001); cyc(1, 4'b0000);
        chk("lit_tail_chase_safe", 32'(suicide), 0);
        chk("lit_tail_chase_head", 32'(head_y), 15);

        fx = 4'd12; fy = 4'd14; cyc(1, 4'b0000);
        chk("lit_grow5_len", 32'(len), 5);
        fx = 4'd0; fy = 4'd15;
        cyc(0, 4'b1000); cyc(1, 4'b0000);
        cyc(0, 4'b0010); cyc(1, 4'b0000);
        chk("lit_pre_collide", 32'(suicide), 0);
        cyc(0, 4'b0100); cyc(1, 4'b0000);
        chk("lit_collide", 32'(suicide), 1);
        repeat (3) cyc(1, 4'b0000);
        chk("lit_frozen_head_x", 32'(head_x), 13);
        chk("lit_frozen_score", 32'(score), 2);

        state = 2'b00; cyc(0, 4'b0000);
        chk("lit_idle_clears", 32'(suicide), 0);
        state = 2'b01;
        for (int k = 0; k < 10; k++) begin
            fx = 4'((9 + k) % W); fy = 4'd8;
            cyc(1, 4'b0000);
        end
        chk("lit_ten_score", 32'(score), 10);
        chk("lit_ten_len", 32'(len), 13);
        state = 2'b10; fx = 4'd0; fy = 4'd15;
        cyc(1, 4'b0000); cyc(1, 4'b0000);
        chk("lit_win_frozen", 32'(head_x), 2);
        state = 2'b01; rst_n = 1'b0; fx = 4'd3; fy = 4'd8;
        cyc(1, 4'b0000);
        chk("lit_reset_beats_tick", 32'(head_x), 8);
        chk("lit_reset_beats_tick_len", 32'(len), 3);
        rst_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            rst_n = (r != 0);
            pick = $urandom_range(0, 99);
            state = (pick < 2) ? 2'b00 : (pick < 4) ? 2'b10 : (pick < 5) ? 2'b11 : 2'b01;
            t = ($urandom_range(0, 2) == 0);
            b = (t || $urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (t && $urandom_range(0, 1) == 1) begin
                fx = 4'(step_x(m_bx[0], m_pend));
                fy = 4'(step_y(m_by[0], m_pend));
            end else begin
                fx = 4'($urandom_range(0, 15));
                fy = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, m_bx.size() - 1);
                qx = 4'(m_bx[pick]);
                qy = 4'(m_by[pick]);
            end else begin
                qx = 4'($urandom_range(0, 15));
                qy = 4'($urandom_range(0, 15));
            end
            tick = t;
            btn  = b;
            @(posedge clk);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
